// File: rtl/jk_bank_arbiter_if.sv
// Purpose : bundle of the requester-side and bank-side signals of jk_bank_arbiter.
// Latency : n/a (wires only).
// Backpressure: none; a requester holds req until it observes its gnt bit.
// Ports   : req/op/mask/lock driven by requesters; gnt/J/K/Q driven by the arbiter.
//           master = requester view, slave = arbiter view.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [NREQ-1:0]       lock;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      J;
  logic [WIDTH-1:0]      K;
  logic [WIDTH-1:0]      Q;

  modport master (
    output req, op, mask, lock,
    input  gnt, J, K, Q
  );

  modport slave (
    input  req, op, mask, lock,
    output gnt, J, K, Q
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Purpose : round-robin arbiter sharing one WIDTH-bit JK flip-flop bank among NREQ requesters.
// Latency : req -> gnt/J/K 1 cycle; req -> Q change 2 cycles; one grant per cycle.
// Backpressure: requesters hold req until their gnt bit is seen; the current grantee is not eligible.
// Ports   : clk, rst (synchronous, active-high); bus (jk_bank_arbiter_if.slave):
//           req/op/mask/lock in, gnt (one-hot, registered), J/K (registered), Q (bank state) out.
// Option  : define JK_ARB_LOCK_EN to let a granted requester with lock=1 keep the grant.
module jk_bank_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic            clk,
  input  logic            rst,
  jk_bank_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] j_q, k_q, q_q;
  logic [WIDTH-1:0] j_d, k_d;

  logic [NREQ-1:0]  elig;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  int               scan_idx;

  logic             hold_vld;
  logic [PW-1:0]    hold_idx;

  logic             sel_vld;
  logic [PW-1:0]    sel_idx;
  logic             adv;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] mask_sel;

  // Round-robin scan starting at the pointer. The current grantee is masked
  // out so a requester still dropping req is never granted twice.
  always_comb begin
    elig     = bus.req & ~gnt_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      cand = PW'(scan_idx);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef JK_ARB_LOCK_EN
  // A locked grantee keeps the bank; it overrides the pointer scan.
  always_comb begin
    hold_vld = |(gnt_q & bus.req & bus.lock);
    hold_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) hold_idx = PW'(i);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign hold_vld    = 1'b0;
  assign hold_idx    = '0;
`endif

  // Final selection and J/K formation from the winner's op and mask.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    adv      = 1'b0;
    op_sel   = 2'b00;
    mask_sel = '0;
    gnt_d    = '0;
    j_d      = '0;
    k_d      = '0;
    ptr_d    = ptr_q;

    if (hold_vld) begin
      sel_vld = 1'b1;
      sel_idx = hold_idx;
    end else if (win_vld) begin
      sel_vld = 1'b1;
      sel_idx = win_idx;
      adv     = 1'b1;
    end

    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == PW'(i)) begin
        op_sel   = bus.op[2*i +: 2];
        mask_sel = bus.mask[WIDTH*i +: WIDTH];
      end
    end

    if (sel_vld) begin
      gnt_d = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
      j_d   = mask_sel & {WIDTH{op_sel[1]}};
      k_d   = mask_sel & {WIDTH{op_sel[0]}};
    end

    if (adv) begin
      ptr_d = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= '0;
      j_q   <= '0;
      k_q   <= '0;
      q_q   <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      j_q   <= j_d;
      k_q   <= k_d;
      ptr_q <= ptr_d;
      // Characteristic JK equation: set on J, clear on K, toggle on both.
      q_q   <= (j_q & ~q_q) | (~k_q & q_q);
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.J   = j_q;
  assign bus.K   = k_q;
  assign bus.Q   = q_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Purpose : directed bench for jk_bank_arbiter with a per-cycle reference model.
// Latency : model mirrors the 1-cycle grant and 2-cycle Q update.
// Backpressure: bench requesters drop req on seeing gnt when auto_drop is set.
module tb_jk_bank_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;

  logic clk;
  logic rst;
  jk_bank_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  jk_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;
  logic [NREQ-1:0] auto_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act[7:0], exp[7:0], $time);
    end
  endtask

  // Reference model: bank as an array of bits, grantee as an integer index.
  int          m_g;
  int          m_ptr;
  logic [WIDTH-1:0] m_j, m_k, m_q;

  always @(posedge clk) begin
    int w;
    bit adv;
    if (rst) begin
      m_g = -1; m_ptr = 0; m_j = '0; m_k = '0; m_q = '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({m_j[b], m_k[b]})
          2'b01:   m_q[b] = 1'b0;
          2'b10:   m_q[b] = 1'b1;
          2'b11:   m_q[b] = ~m_q[b];
          default: m_q[b] = m_q[b];
        endcase
      end
      w = -1;
      adv = 1'b1;
`ifdef JK_ARB_LOCK_EN
      if (m_g >= 0 && bus.req[m_g] && bus.lock[m_g]) begin
        w = m_g;
        adv = 1'b0;
      end
`endif
      if (w < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (w < 0 && bus.req[c] && c != m_g) w = c;
        end
      end
      if (w >= 0) begin
        m_j = bus.mask[WIDTH*w +: WIDTH] & (bus.op[2*w+1] ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
        m_k = bus.mask[WIDTH*w +: WIDTH] & (bus.op[2*w]   ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
        if (adv) m_ptr = (w + 1) % NREQ;
        m_g = w;
      end else begin
        m_j = '0; m_k = '0; m_g = -1;
      end
    end
  end

  function automatic logic [NREQ-1:0] m_gnt();
    logic [NREQ-1:0] v;
    v = '0;
    if (m_g >= 0) v[m_g] = 1'b1;
    return v;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_gnt", 32'(bus.gnt), 32'(m_gnt()));
      check("model_J",   32'(bus.J),   32'(m_j));
      check("model_K",   32'(bus.K),   32'(m_k));
      check("model_Q",   32'(bus.Q),   32'(m_q));
    end
  end

  task automatic put_req(input int i, input logic [1:0] o, input logic [WIDTH-1:0] m, input bit drop);
    bus.op[2*i +: 2]       = o;
    bus.mask[WIDTH*i +: WIDTH] = m;
    bus.req[i]             = 1'b1;
    auto_drop[i]           = drop;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (auto_drop[i] && bus.gnt[i]) bus.req[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.op = '0; bus.mask = '0; bus.lock = '0;
    @(negedge clk);

    // Reset with every requester asserting.
    bus.req = '1;
    bus.op  = '1;
    bus.mask = '1;
    for (int c = 0; c < 2; c++) begin
      step();
      cmp_en = 1'b1;
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_J",   32'(bus.J),   32'h0);
      check("rst_K",   32'(bus.K),   32'h0);
      check("rst_Q",   32'(bus.Q),   32'h0);
    end
    bus.req = '0; bus.op = '0; bus.mask = '0;
    rst = 1'b0;
    step();

    // Single set, then reset of one bit.
    put_req(0, 2'b10, 4'b0101, 1'b1);
    step();
    check("set_gnt", 32'(bus.gnt), 32'b0001);
    check("set_J",   32'(bus.J),   32'b0101);
    check("set_K",   32'(bus.K),   32'b0000);
    put_req(1, 2'b01, 4'b0100, 1'b1);
    step();
    check("set_Q",   32'(bus.Q),   32'b0101);
    check("clr_gnt", 32'(bus.gnt), 32'b0010);
    step();
    check("clr_Q",   32'(bus.Q),   32'b0001);

    // Return pointer to 0 for the simultaneous-request case.
    rst = 1'b1;
    step();
    check("rst2_Q", 32'(bus.Q), 32'h0);
    rst = 1'b0;

    put_req(0, 2'b10, 4'b1111, 1'b1);
    put_req(1, 2'b01, 4'b0011, 1'b1);
    put_req(2, 2'b11, 4'b1111, 1'b1);
    put_req(3, 2'b00, 4'b1111, 1'b1);
    step(); check("sim_gnt0", 32'(bus.gnt), 32'b0001);
    step(); check("sim_gnt1", 32'(bus.gnt), 32'b0010); check("sim_Q0", 32'(bus.Q), 32'b1111);
    step(); check("sim_gnt2", 32'(bus.gnt), 32'b0100); check("sim_Q1", 32'(bus.Q), 32'b1100);
    step(); check("sim_gnt3", 32'(bus.gnt), 32'b1000); check("sim_Q2", 32'(bus.Q), 32'b0011);
    step(); check("sim_gnt4", 32'(bus.gnt), 32'b0000); check("sim_Q3", 32'(bus.Q), 32'b0011);

    // Fairness: req1 and req3 held continuously.
    put_req(1, 2'b00, 4'b0000, 1'b0);
    put_req(3, 2'b00, 4'b0000, 1'b0);
    step(); check("fair_0", 32'(bus.gnt), 32'b0010);
    step(); check("fair_1", 32'(bus.gnt), 32'b1000);
    step(); check("fair_2", 32'(bus.gnt), 32'b0010);
    step(); check("fair_3", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    step();
    check("fair_idle", 32'(bus.gnt), 32'b0000);

    // Toggle bit 3 twice; other bits stay untouched.
    put_req(2, 2'b11, 4'b1000, 1'b0);
    step(); check("tog_gnt0", 32'(bus.gnt), 32'b0100);
    step(); check("tog_gap",  32'(bus.gnt), 32'b0000); check("tog_Q0", 32'(bus.Q), 32'b1011);
    step(); check("tog_gnt1", 32'(bus.gnt), 32'b0100);
    bus.req[2] = 1'b0;
    step(); check("tog_Q1",   32'(bus.Q),   32'b0011);

    // Lock: req0 locked for three cycles while req2 waits.
    put_req(0, 2'b10, 4'b0001, 1'b0);
    bus.lock[0] = 1'b1;
    put_req(2, 2'b10, 4'b0100, 1'b1);
`ifdef JK_ARB_LOCK_EN
    step(); check("lock_0", 32'(bus.gnt), 32'b0001);
    step(); check("lock_1", 32'(bus.gnt), 32'b0001);
    step(); check("lock_2", 32'(bus.gnt), 32'b0001);
    bus.req[0] = 1'b0; bus.lock[0] = 1'b0;
    step(); check("lock_3", 32'(bus.gnt), 32'b0100);
`else
    step(); check("lock_0", 32'(bus.gnt), 32'b0001);
    step(); check("lock_1", 32'(bus.gnt), 32'b0100);
    step(); check("lock_2", 32'(bus.gnt), 32'b0001);
    bus.req[0] = 1'b0; bus.lock[0] = 1'b0;
    step(); check("lock_idle", 32'(bus.gnt), 32'b0000);
    put_req(2, 2'b10, 4'b0100, 1'b1);
    step(); check("lock_3", 32'(bus.gnt), 32'b0100);
`endif

    // Reset while req2 holds the grant: its pending set must be discarded.
    rst = 1'b1;
    step();
    check("mid_rst_gnt", 32'(bus.gnt), 32'b0000);
    check("mid_rst_Q",   32'(bus.Q),   32'b0000);
    rst = 1'b0;
    step();
    check("post_rst_Q",  32'(bus.Q),   32'b0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
